fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage MIPS pipeline, sitting in ID.
- Compares the instruction in ID with those in EX and MEM.
- Registers the 2-bit operand-select codes into the EX stage; these drive the sel inputs of the two EX operand 4:1 muxes.
- Also generates load-use and mult/div stall, bubble and flush control, and tracks the multi-cycle mult/div unit with a busy counter.

---
 rtl/fwd_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - ID-stage forwarding select, load-use / mult-div stall and flush control
module fwd_hazard_ctrl #(
  parameter int MD_CYCLES = 8,
  parameter int REG_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_md,
  input  logic             id_reads_hilo,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic             flush_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             md_busy
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LD_STALL = 2'b01,
    MD_STALL = 2'b10
  } state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_EX  = 2'b10;

  state_t     state;
  logic [7:0] md_cnt;

  logic ld_haz;
  logic md_haz;
  logic ex_fwd_ok;
  logic mem_fwd_ok;
  logic advance;
  logic [1:0] next_a;
  logic [1:0] next_b;

  assign md_busy = (md_cnt != 8'd0);

  // Register 0 is hard-wired zero, so a write to it never creates a dependency.
  assign ld_haz = id_valid & ex_memread & ex_regwrite & (ex_rd != '0) &
                  ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  assign md_haz = id_valid & md_busy & (id_is_md | id_reads_hilo);

  assign ex_fwd_ok  = ex_regwrite & ~ex_memread & (ex_rd != '0);
  assign mem_fwd_ok = mem_regwrite & (mem_rd != '0);

  always_comb begin
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    if (flush_ex) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (ld_haz | md_haz) begin
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end
  end

  assign advance = ~flush_ex & ~ld_haz & ~md_haz;

  // EX producer is younger than MEM producer, so it wins when both match.
  always_comb begin
    next_a = SEL_RF;
    next_b = SEL_RF;
    if (id_valid && !bubble_id_ex) begin
      if (ex_fwd_ok && (ex_rd == id_rs))
        next_a = SEL_EX;
      else if (mem_fwd_ok && (mem_rd == id_rs))
        next_a = SEL_MEM;

      if (ex_fwd_ok && (ex_rd == id_rt))
        next_b = SEL_EX;
      else if (mem_fwd_ok && (mem_rd == id_rt))
        next_b = SEL_MEM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else begin
      fwd_a_sel <= next_a;
      fwd_b_sel <= next_b;
    end
  end

  // A flush leaves an in-flight mult/div running; only a fresh issue reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= 8'd0;
    end else if (advance && id_valid && id_is_md) begin
      md_cnt <= 8'(MD_CYCLES);
    end else if (md_cnt != 8'd0) begin
      md_cnt <= md_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else if (flush_ex) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (ld_haz)
            state <= LD_STALL;
          else if (md_haz)
            state <= MD_STALL;
          else
            state <= RUN;
        end
        LD_STALL: state <= md_haz ? MD_STALL : RUN;
        MD_STALL: state <= md_haz ? MD_STALL : RUN;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed-vector bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_is_md;
  logic       id_reads_hilo;
  logic [4:0] ex_rd;
  logic       ex_regwrite;
  logic       ex_memread;
  logic [4:0] mem_rd;
  logic       mem_regwrite;
  logic       flush_ex;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall_if_id;
  logic       bubble_id_ex;
  logic       flush_if_id;
  logic       md_busy;

  int checks   = 0;
  int failures = 0;

  fwd_hazard_ctrl #(.MD_CYCLES(8), .REG_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_is_md     (id_is_md),
    .id_reads_hilo(id_reads_hilo),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .flush_ex     (flush_ex),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_if_id  (stall_if_id),
    .bubble_id_ex (bubble_id_ex),
    .flush_if_id  (flush_if_id),
    .md_busy      (md_busy)
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    id_is_md = 0; id_reads_hilo = 0;
    ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; flush_ex = 0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    #1;
    checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL reset_fwd_a: got %b expected 00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin failures++; $display("FAIL reset_fwd_b: got %b expected 00", fwd_b_sel); end
    checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL reset_md_busy: got %b expected 0", md_busy); end
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall_if_id); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    next_edge();
  endtask

  task automatic test_ex_forward();
    idle();
    ex_rd = 8; ex_regwrite = 1;
    id_valid = 1; id_rs = 8; id_rt = 8; id_uses_rt = 1;
    @(negedge clk);
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL ex_fwd_stall: got %b expected 0", stall_if_id); end
    checks++; if (bubble_id_ex !== 1'b0) begin failures++; $display("FAIL ex_fwd_bubble: got %b expected 0", bubble_id_ex); end
    next_edge();
    checks++; if (fwd_a_sel !== 2'b10) begin failures++; $display("FAIL ex_fwd_a: got %b expected 10", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b10) begin failures++; $display("FAIL ex_fwd_b: got %b expected 10", fwd_b_sel); end
  endtask

  task automatic test_mem_forward();
    idle();
    mem_rd = 8; mem_regwrite = 1;
    id_valid = 1; id_rs = 8; id_rt = 8; id_uses_rt = 0;
    next_edge();
    checks++; if (fwd_a_sel !== 2'b01) begin failures++; $display("FAIL mem_fwd_a: got %b expected 01", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b01) begin failures++; $display("FAIL mem_fwd_b_rt_unused: got %b expected 01", fwd_b_sel); end
    ex_rd = 8; ex_regwrite = 1;
    next_edge();
    checks++; if (fwd_a_sel !== 2'b10) begin failures++; $display("FAIL ex_over_mem_a: got %b expected 10", fwd_a_sel); end
    idle();
    id_valid = 1; ex_regwrite = 1; mem_regwrite = 1;
    next_edge();
    checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL rd_zero_a: got %b expected 00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin failures++; $display("FAIL rd_zero_b: got %b expected 00", fwd_b_sel); end
    idle();
    mem_rd = 8; mem_regwrite = 1; id_rs = 8;
    next_edge();
    checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL invalid_id_a: got %b expected 00", fwd_a_sel); end
  endtask

  task automatic test_load_use();
    idle();
    ex_rd = 8; ex_regwrite = 1; ex_memread = 1;
    id_valid = 1; id_rs = 8; id_rt = 1; id_uses_rt = 1;
    @(negedge clk);
    checks++; if (stall_if_id !== 1'b1) begin failures++; $display("FAIL ld_c1_stall: got %b expected 1", stall_if_id); end
    checks++; if (bubble_id_ex !== 1'b1) begin failures++; $display("FAIL ld_c1_bubble: got %b expected 1", bubble_id_ex); end
    next_edge();
    checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL ld_c1_fwd_a: got %b expected 00", fwd_a_sel); end
    checks++; if (dut.state !== 2'b01) begin failures++; $display("FAIL ld_c1_state: got %b expected 01", dut.state); end
    ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 8; mem_regwrite = 1;
    @(negedge clk);
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL ld_c2_stall: got %b expected 0", stall_if_id); end
    next_edge();
    checks++; if (fwd_a_sel !== 2'b01) begin failures++; $display("FAIL ld_c2_fwd_a: got %b expected 01", fwd_a_sel); end
    checks++; if (dut.state !== 2'b00) begin failures++; $display("FAIL ld_c2_state: got %b expected 00", dut.state); end
    idle();
    ex_rd = 8; ex_regwrite = 1; ex_memread = 1;
    id_valid = 1; id_rs = 3; id_rt = 8; id_uses_rt = 0;
    @(negedge clk);
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL ld_rt_unused_stall: got %b expected 0", stall_if_id); end
    id_uses_rt = 1;
    #1;
    checks++; if (stall_if_id !== 1'b1) begin failures++; $display("FAIL ld_rt_used_stall: got %b expected 1", stall_if_id); end
    ex_rd = 0; id_rs = 0; id_rt = 0;
    #1;
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL ld_r0_stall: got %b expected 0", stall_if_id); end
    next_edge();
  endtask

  task automatic test_mult_div();
    int stalls;
    bit done;
    idle();
    next_edge();
    id_valid = 1; id_is_md = 1;
    @(negedge clk);
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL md_issue_stall: got %b expected 0", stall_if_id); end
    next_edge();
    idle();
    @(negedge clk);
    checks++; if (md_busy !== 1'b1) begin failures++; $display("FAIL md_busy_after_issue: got %b expected 1", md_busy); end
    next_edge();
    id_valid = 1; id_reads_hilo = 1;
    stalls = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall_if_id) begin
        stalls++;
        next_edge();
      end else begin
        done = 1;
      end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL md_timeout: stall never released within 20 cycles"); end
    checks++; if (stalls !== 7) begin failures++; $display("FAIL md_stall_count: got %0d expected 7", stalls); end
    checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL md_busy_on_advance: got %b expected 0", md_busy); end
    next_edge();
    checks++; if (dut.state !== 2'b00) begin failures++; $display("FAIL md_state_after: got %b expected 00", dut.state); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    id_valid = 1; id_is_md = 1;
    next_edge();
    idle();
    id_valid = 1; id_reads_hilo = 1;
    next_edge();
    checks++; if (dut.state !== 2'b10) begin failures++; $display("FAIL flush_pre_state: got %b expected 10", dut.state); end
    id_rs = 8; ex_rd = 8; ex_regwrite = 1; ex_memread = 1; flush_ex = 1;
    @(negedge clk);
    checks++; if (flush_if_id !== 1'b1) begin failures++; $display("FAIL flush_flush: got %b expected 1", flush_if_id); end
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b expected 0", stall_if_id); end
    checks++; if (bubble_id_ex !== 1'b1) begin failures++; $display("FAIL flush_bubble: got %b expected 1", bubble_id_ex); end
    next_edge();
    checks++; if (dut.state !== 2'b00) begin failures++; $display("FAIL flush_state: got %b expected 00", dut.state); end
    checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL flush_fwd_a: got %b expected 00", fwd_a_sel); end
    checks++; if (md_busy !== 1'b1) begin failures++; $display("FAIL flush_keeps_md: got %b expected 1", md_busy); end
    checks++; if (dut.md_cnt !== 8'd6) begin failures++; $display("FAIL flush_md_cnt: got %0d expected 6", dut.md_cnt); end
    idle();
    for (int i = 0; i < 20 && md_busy; i++) next_edge();
    checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL flush_drain: md_busy still %b after 20 cycles", md_busy); end
  endtask

  task automatic test_reset_mid_run();
    idle();
    id_valid = 1; id_is_md = 1; id_rs = 8;
    ex_rd = 8; ex_regwrite = 1;
    next_edge();
    id_is_md = 0;
    repeat (3) next_edge();
    checks++; if (fwd_a_sel !== 2'b10) begin failures++; $display("FAIL mid_pre_fwd_a: got %b expected 10", fwd_a_sel); end
    checks++; if (dut.md_cnt !== 8'd5) begin failures++; $display("FAIL mid_pre_md_cnt: got %0d expected 5", dut.md_cnt); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL mid_rst_fwd_a: got %b expected 00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin failures++; $display("FAIL mid_rst_fwd_b: got %b expected 00", fwd_b_sel); end
    checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_md_busy: got %b expected 0", md_busy); end
    idle();
    @(negedge clk);
    rst_n = 1;
    next_edge();
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_mult_div();
    test_flush();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
